// File: rtl/soc_pkg.sv
// Shared SoC constants: memory widths, requester port ids and lock state encoding.
package soc_pkg;

  localparam int DMEM_WIDTH_DEF = 9;
  localparam int PMEM_WIDTH_DEF = 10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with lock override; purely combinational, one-hot grant.
// A requesting lock owner always wins; otherwise a lone requester wins, and on contention the port not granted last wins.
module rr_arb2
  import soc_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_lock_vld,
  input  logic       i_lock_owner,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

  logic w_other;

  assign w_other = (i_last_gnt == PORT_CPU) ? PORT_DBG : PORT_CPU;

  always_comb begin
    o_gnt = 2'b00;
    if (i_lock_vld && i_req[i_lock_owner]) begin
      o_gnt[i_lock_owner] = 1'b1;
    end else if (i_req == 2'b11) begin
      o_gnt[w_other] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between CPU and debug ports; grant is same-cycle, read data returns 2 cycles after grant.
// Requesters hold their request until granted; one RAM access per cycle, bursts bounded by LOCK_MAX.
module dmem_arbiter
  import soc_pkg::*;
#(
  parameter int DMEM_WIDTH = DMEM_WIDTH_DEF,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic                  i_lock0,
  input  logic                  i_lock1,
  input  logic [DMEM_WIDTH-1:0] i_a0,
  input  logic [DMEM_WIDTH-1:0] i_a1,
  input  logic [7:0]            i_wd0,
  input  logic [7:0]            i_wd1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [7:0]            o_rdata,
  output logic                  o_dmem_re,
  output logic                  o_dmem_we,
  output logic [DMEM_WIDTH-1:0] o_dmem_a,
  output logic [7:0]            o_dmem_di,
  input  logic [7:0]            i_dmem_do
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  lock_state_e           r_lock_state, w_lock_state_nxt;
  logic                  r_lock_owner, w_lock_owner_nxt;
  logic [7:0]            r_lock_cnt, w_lock_cnt_nxt;
  logic                  r_last_gnt;

  logic [1:0]            w_req, w_lock, w_arb_gnt, w_gnt;
  logic                  w_gnt_vld, w_gnt_port, w_gnt_we;
  logic [DMEM_WIDTH-1:0] w_gnt_a;
  logic [7:0]            w_gnt_wd;
  logic [7:0]            w_cnt_inc;

  logic                  r_dmem_re, r_dmem_we, r_tag;
  logic [DMEM_WIDTH-1:0] r_dmem_a;
  logic [7:0]            r_dmem_di;
  logic                  r_rvalid0, r_rvalid1;

  assign w_req  = {i_req1, i_lock1 & 1'b0 | i_req1 & 1'b0 | i_req0 & 1'b0 | 1'b0} | {1'b0, i_req0};
  assign w_lock = {i_lock1, i_lock0};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_lock_vld   (r_lock_state == LOCK_HELD),
    .i_lock_owner (r_lock_owner),
    .i_last_gnt   (r_last_gnt),
    .o_gnt        (w_arb_gnt)
  );

  // No grant may be issued while reset is asserted.
  assign w_gnt      = w_arb_gnt & {2{i_rst_n}};
  assign w_gnt_vld  = |w_gnt;
  assign w_gnt_port = w_gnt[1];
  assign w_gnt_we   = w_gnt_port ? i_we1 : i_we0;
  assign w_gnt_a    = w_gnt_port ? i_a1  : i_a0;
  assign w_gnt_wd   = w_gnt_port ? i_wd1 : i_wd0;
  assign w_cnt_inc  = r_lock_cnt + 8'd1;

  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_lock_owner_nxt = r_lock_owner;
    w_lock_cnt_nxt   = r_lock_cnt;
    if (r_lock_state == LOCK_HELD && w_req[r_lock_owner]) begin
      if (w_gnt_vld) begin
        if (!w_lock[r_lock_owner] || w_cnt_inc == LOCK_MAX_C) begin
          w_lock_state_nxt = LOCK_IDLE;
          w_lock_cnt_nxt   = 8'd0;
        end else begin
          w_lock_cnt_nxt   = w_cnt_inc;
        end
      end
    end else begin
      // Unlocked, or the owner dropped its request: a fresh grant may start a new lock.
      w_lock_state_nxt = LOCK_IDLE;
      w_lock_cnt_nxt   = 8'd0;
      if (w_gnt_vld && w_lock[w_gnt_port] && LOCK_MAX_C != 8'd1) begin
        w_lock_state_nxt = LOCK_HELD;
        w_lock_owner_nxt = w_gnt_port;
        w_lock_cnt_nxt   = 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lock_state <= LOCK_IDLE;
      r_lock_owner <= PORT_CPU;
      r_lock_cnt   <= 8'd0;
      r_last_gnt   <= PORT_DBG;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      if (w_gnt_vld) begin
        r_last_gnt <= w_gnt_port;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dmem_re <= 1'b0;
      r_dmem_we <= 1'b0;
      r_dmem_a  <= '0;
      r_dmem_di <= 8'd0;
      r_tag     <= PORT_CPU;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_dmem_re <= w_gnt_vld & ~w_gnt_we;
      r_dmem_we <= w_gnt_vld & w_gnt_we;
      if (w_gnt_vld) begin
        r_dmem_a  <= w_gnt_a;
        r_dmem_di <= w_gnt_wd;
        r_tag     <= w_gnt_port;
      end
      r_rvalid0 <= r_dmem_re & (r_tag == PORT_CPU);
      r_rvalid1 <= r_dmem_re & (r_tag == PORT_DBG);
    end
  end

  assign o_gnt0    = w_gnt[0];
  assign o_gnt1    = w_gnt[1];
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata   = i_dmem_do;
  assign o_dmem_re = r_dmem_re;
  assign o_dmem_we = r_dmem_we;
  assign o_dmem_a  = r_dmem_a;
  assign o_dmem_di = r_dmem_di;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a behavioural RAM and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW       = 9;
  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [7:0] wd0 = 8'd0, wd1 = 8'd0;
  logic gnt0, gnt1, rvalid0, rvalid1, dmem_re, dmem_we;
  logic [7:0] rdata, dmem_di, dmem_do;
  logic [AW-1:0] dmem_a;

  dmem_arbiter #(.DMEM_WIDTH(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_lock0(lock0), .i_lock1(lock1), .i_a0(a0), .i_a1(a1),
    .i_wd0(wd0), .i_wd1(wd1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata(rdata), .o_dmem_re(dmem_re), .o_dmem_we(dmem_we),
    .o_dmem_a(dmem_a), .o_dmem_di(dmem_di), .i_dmem_do(dmem_do)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: data out valid the cycle after a read enable.
  logic [7:0] ram [2**AW];
  always @(posedge clk) begin
    if (dmem_we === 1'b1) ram[dmem_a] = dmem_di;
    if (dmem_re === 1'b1) dmem_do <= ram[dmem_a];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [7:0] ref_mem [2**AW];
  int m_last = 1;
  int m_owner = -1;
  int m_streak = 0;

  typedef struct { int due; bit we; logic [AW-1:0] a; logic [7:0] d; } acc_t;
  typedef struct { int due; int port; logic [7:0] d; } rd_t;
  acc_t acc_q[$];
  rd_t  rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT drives a RAM access or a read return.
  always @(negedge clk) begin
    acc_t ea;
    rd_t  er;
    if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
      ea = acc_q.pop_front();
      chk("dmem_re", dmem_re, !ea.we);
      chk("dmem_we", dmem_we, ea.we);
      chk("dmem_a", dmem_a, ea.a);
      chk("dmem_di", dmem_di, ea.d);
    end else begin
      chk("dmem_idle", {dmem_re, dmem_we}, 2'b00);
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      er = rd_q.pop_front();
      chk("rvalid0", rvalid0, er.port == 0);
      chk("rvalid1", rvalid1, er.port == 1);
      chk("rdata", rdata, er.d);
    end else begin
      chk("rvalid_idle", {rvalid0, rvalid1}, 2'b00);
    end
  end

  task automatic set_port(input int p, input bit r, input bit w, input bit l, input int a, input int d);
    logic [31:0] av, dv;
    av = a; dv = d;
    if (p == 0) begin req0 = r; we0 = w; lock0 = l; a0 = av[AW-1:0]; wd0 = dv[7:0]; end
    else        begin req1 = r; we1 = w; lock1 = l; a1 = av[AW-1:0]; wd1 = dv[7:0]; end
  endtask

  // One clock cycle: predict the winner from the arbitration rules, compare, queue pipeline results.
  task automatic eval_cycle(input bit chk_rst, output bit g0, output bit g1);
    bit rq[2];
    bit lk[2];
    int win;
    acc_t ea;
    rd_t er;
    @(negedge clk);
    rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1;
    win = -1;
    if (rst_n !== 1'b1) begin
      m_last = 1; m_owner = -1; m_streak = 0;
      for (int i = rd_q.size() - 1; i >= 0; i--)
        if (rd_q[i].due > cyc) rd_q.delete(i);
    end else begin
      if (m_owner >= 0 && rq[m_owner]) win = m_owner;
      else if (rq[0] && rq[1]) win = 1 - m_last;
      else if (rq[0]) win = 0;
      else if (rq[1]) win = 1;
      if (m_owner >= 0 && !rq[m_owner]) begin m_owner = -1; m_streak = 0; end
      if (win >= 0) begin
        if (m_owner == win) begin
          m_streak++;
          if (!lk[win] || m_streak == LOCK_MAX) begin m_owner = -1; m_streak = 0; end
        end else if (lk[win]) begin
          m_streak = 1;
          m_owner = (LOCK_MAX == 1) ? -1 : win;
        end
        m_last = win;
        ea.due = cyc + 1;
        ea.we  = (win == 0) ? we0 : we1;
        ea.a   = (win == 0) ? a0 : a1;
        ea.d   = (win == 0) ? wd0 : wd1;
        acc_q.push_back(ea);
        if (ea.we) ref_mem[ea.a] = ea.d;
        else begin
          er.due = cyc + 2; er.port = win; er.d = ref_mem[ea.a];
          rd_q.push_back(er);
        end
      end
    end
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    if (chk_rst) begin
      chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
      chk("rst_re_we", {dmem_re, dmem_we}, 2'b00);
      chk("rst_dmem_a", dmem_a, 0);
      chk("rst_dmem_di", dmem_di, 0);
    end
    g0 = (gnt0 === 1'b1);
    g1 = (gnt1 === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) eval_cycle(0, g0, g1);
  endtask

  task automatic do_reset();
    bit g0, g1;
    rst_n = 1'b0;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    eval_cycle(0, g0, g1);
    eval_cycle(1, g0, g1);
    rst_n = 1'b1;
  endtask

  initial begin
    bit g0, g1;
    bit pend[2];
    int hist[20];
    int n0, busy;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    do_reset();

    // Single read from a preloaded location.
    ram[5] = 8'hA5; ref_mem[5] = 8'hA5;
    set_port(0, 1, 0, 0, 'h05, 0);
    eval_cycle(0, g0, g1);
    chk("single_read_gnt0", g0, 1);
    idle(3);

    // Contention from reset: grants alternate starting with port 0.
    do_reset();
    set_port(0, 1, 0, 0, 'h10, 0);
    set_port(1, 1, 0, 0, 'h20, 0);
    for (int k = 0; k < 4; k++) begin
      eval_cycle(0, g0, g1);
      chk("contention_seq", g1 ? 1 : (g0 ? 0 : 2), k % 2);
    end
    idle(3);

    // Write then read the top address on port 1.
    set_port(1, 1, 1, 0, 'h1FF, 'h3C);
    eval_cycle(0, g0, g1);
    set_port(1, 1, 0, 0, 'h1FF, 0);
    eval_cycle(0, g0, g1);
    chk("raw_read_gnt1", g1, 1);
    idle(3);

    // Lock bound with both ports requesting continuously.
    do_reset();
    set_port(0, 1, 0, 1, 'h33, 0);
    set_port(1, 1, 0, 0, 'h44, 0);
    for (int k = 0; k < 20; k++) begin
      eval_cycle(0, g0, g1);
      hist[k] = g0 ? 0 : (g1 ? 1 : 2);
    end
    n0 = 0;
    while (n0 < 20 && hist[n0] == 0) n0++;
    chk("lock_run_len", n0, LOCK_MAX);
    chk("lock_handover", hist[LOCK_MAX], 1);
    set_port(0, 1, 0, 0, 'h33, 0);
    eval_cycle(0, g0, g1);
    eval_cycle(0, g0, g1);
    chk("lock_early_release", g1, 1);
    idle(3);

    // Reset in the cycle after a read grant.
    set_port(0, 1, 0, 0, 'h05, 0);
    eval_cycle(0, g0, g1);
    chk("mid_reset_gnt0", g0, 1);
    rst_n = 1'b0;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 1, 0, 0, 'h07, 0);
    eval_cycle(0, g0, g1);
    eval_cycle(1, g0, g1);
    rst_n = 1'b1;
    set_port(0, 1, 0, 0, 'h08, 0);
    set_port(1, 1, 0, 0, 'h09, 0);
    eval_cycle(0, g0, g1);
    chk("post_reset_first_gnt0", g0, 1);
    idle(3);

    // Idle stretch.
    busy = 0;
    for (int k = 0; k < 10; k++) begin
      eval_cycle(0, g0, g1);
      busy += int'(dmem_re | dmem_we | gnt0 | gnt1 | rvalid0 | rvalid1);
    end
    chk("idle_quiet", busy, 0);

    // Randomized traffic.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            set_port(p, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 2**AW - 1),
                     $urandom_range(0, 255));
            pend[p] = 1;
          end else begin
            set_port(p, 0, 0, 1'($urandom_range(0, 1)), 0, 0);
          end
        end
      end
      eval_cycle(0, g0, g1);
      if (g0) pend[0] = 0;
      if (g1) pend[1] = 0;
    end
    idle(4);
    chk("drain_empty", acc_q.size() + rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port 8-bit data RAM between requester 0 (CPU core load/store unit) and requester 1 (debug/IO DMA port, e.g. LED mirror).
- Sits between the requesters and the ram instance and drives its re/we/address/data pins.
- Round-robin arbitration with optional bounded lock for bursts; pipelined, one access accepted per cycle, fixed read latency.

Parameters:
- DMEM_WIDTH, 9, RAM address width; must match the ram instance's ram_width.
- LOCK_MAX, 8, maximum consecutive grants to a locking requester before forced handover (range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- lock0 / lock1  in  1  request to keep ownership for following transfers
- a0 / a1  in  DMEM_WIDTH  byte address
- wd0 / wd1  in  8  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata belongs to this port's read
- rdata  out  8  read data, shared; direct from dmem_do
- dmem_re  out  1  RAM read enable
- dmem_we  out  1  RAM write enable
- dmem_a  out  DMEM_WIDTH  RAM address
- dmem_di  out  8  RAM write data
- dmem_do  in  8  RAM read data, valid the cycle after dmem_re

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - gnt*, rvalid*, dmem_re and dmem_we go to 0; dmem_a and dmem_di go to 0.
  - Last-grant pointer goes to 1, so port 0 wins first.
  - Lock owner is cleared and lock_cnt goes to 0.
  - In-flight reads are discarded; no rvalid is issued after reset.
- Request handshake:
  - The requester holds reqN, weN, aN and wdN stable until gntN is sampled high.
  - On the cycle after gntN it may deassert reqN or present a new request.
  - gntN is combinational from the registered state and the current inputs.
- Arbitration, evaluated each cycle:
  - Lock owner active and still requesting: owner wins.
  - Otherwise, if only one requester is asserting reqN, that requester wins.
  - Otherwise, when both request, the port not granted last wins.
  - At most one gnt per cycle; a grant is never issued without a request.
- Pipeline (grant in cycle t):
  - t+1: dmem_re = ~we, dmem_we = we, dmem_a / dmem_di registered from the granted port.
  - t+2, reads only: rvalidN = 1 and rdata = dmem_do. Read latency from gnt to rvalid is 2 cycles.
  - Writes produce no rvalid.
  - Back-to-back grants give one RAM access every cycle; an rvalid pulse from a t-1 grant may coincide with a new grant.
  - A tag register carries the port id from t+1 to t+2.
- Lock, states UNLOCKED and LOCKED(p):
  - UNLOCKED -> LOCKED(p) on a grant to p with lockp = 1; lock_cnt is set to 1.
  - In LOCKED(p), each further grant to p increments lock_cnt.
  - Return to UNLOCKED on any of:
    - lockp = 0 at a grant to p;
    - reqp = 0 for one cycle;
    - lock_cnt reaching LOCK_MAX. The LOCK_MAX-th grant is still issued; the next cycle arbitrates round-robin with p as last-granted, so the other port wins if requesting.
  - While locked, the other port's gnt stays 0.
- Idle cycles: dmem_re = dmem_we = 0; dmem_a and dmem_di hold their last values.
- Read-after-write to the same address on consecutive grants returns the new data, because RAM writes complete at t+1.
- Reset mid-operation: pipeline valid bits are cleared in the same edge, and a pending rvalid is suppressed.

Decomposition:
- Shared package soc_pkg holds:
  - DMEM_WIDTH/PMEM_WIDTH defaults (9/10);
  - port id constants PORT_CPU = 0, PORT_DBG = 1;
  - lock state encoding.
- A natural sub-module is rr_arb2: a 2-way round-robin picker with lock override. It takes req, lock_owner and last_gnt and returns a one-hot grant.
- Pipeline and lock registers stay in dmem_arbiter.

Test Plan:
- Single read: preload RAM[0x05]=0xA5; req0 read a0=0x05 -> gnt0 in the same cycle, dmem_re=1 with dmem_a=0x05 next cycle, rvalid0=1 with rdata=0xA5 two cycles after gnt; rvalid1 stays 0.
- Contention: req0 and req1 both held for 4 cycles (reads at 0x10/0x20) -> grants alternate 0,1,0,1 from reset; rvalid pattern follows 2 cycles later; no idle slot.
- Write then read: req1 write 0x3C to 0x1FF, then read 0x1FF next cycle -> dmem_we then dmem_re on consecutive cycles; rvalid1 with rdata=0x3C.
- Lock bound: LOCK_MAX=8, lock0=1 and req0/req1 held continuously -> exactly 8 consecutive gnt0, then gnt1, then arbitration resumes; lock released early when lock0 drops.
- Reset mid-read: gnt0 for a read in cycle t, rst_n=0 in cycle t+1 -> no rvalid0 at t+2; all outputs 0; first post-reset contention grants port 0.
- Idle: no requests for 10 cycles -> dmem_re and dmem_we remain 0; no gnt or rvalid pulses.
